bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_TENURE, default 16: cycles an owner may hold the bus before it must yield to a waiting master at a transaction boundary.
REQ-002 SHALL have parameter TENURE_W, default 5: width of the tenure counter; it holds MAX_TENURE without overflow.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports m0_req_, m1_req_, m2_req_, m3_req_, each input, 1: bus request from master n, active low.
REQ-006 SHALL have ports m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, each output, 1: bus grant to master n, active low and registered.
REQ-007 SHALL have port bus_rdy_, input, 1: slave-ready, active low; a low value marks completion of the current transfer.
REQ-008 SHALL have port bus_owner, output, 2: index of the granted master; valid only while bus_busy=1.
REQ-009 SHALL have port bus_busy, output, 1: high while any grant is asserted.

Function
REQ-010 SHALL implement two states, IDLE and OWNED, with a 2-bit owner register, a 2-bit priority pointer ptr and a TENURE_W-bit counter tenure.
REQ-011 SHALL, in IDLE with one or more requests low, select the first requester searching ptr, ptr+1, ... mod 4, assert only that grant on the next edge, load owner, clear tenure, and enter OWNED.
REQ-012 SHALL, in IDLE with no request, keep all grants high; request-to-grant latency is exactly 1 cycle.
REQ-013 SHALL, in OWNED, keep exactly one grant low (the owner's) and assert no other grant.
REQ-014 SHALL increment tenure once per OWNED cycle and saturate it at MAX_TENURE.
REQ-015 SHALL treat the owner's req_ going high as a release.
REQ-016 SHALL, on release, search owner+1, owner+2, owner+3 mod 4 in the same cycle.
REQ-017 SHALL, if that search finds a requester, move the grant directly to it on the next edge, with no idle cycle, and clear tenure.
REQ-018 SHALL, if that search finds no requester, deassert all grants on the next edge, set ptr=owner+1 mod 4, and enter IDLE.
REQ-019 SHALL force a yield when tenure=MAX_TENURE, another master is requesting, and bus_rdy_=0 in the same cycle: the grant moves on the next edge exactly as on release, while the old owner's request remains pending.
REQ-020 SHALL never force a yield while bus_rdy_=1, so a transfer in progress is never cut.
REQ-021 SHALL, when the owner is the only requester, hold the grant indefinitely regardless of tenure.
REQ-022 SHALL give release precedence over forced yield when both occur in the same cycle; the outcome is identical either way.
REQ-023 SHALL let a request that drops before being granted be lost, with no latching of requests.
REQ-024 SHALL drive bus_owner and bus_busy from registers in the same cycle as the grants.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, set all grants high, bus_busy=0, bus_owner=0, ptr=0, tenure=0 and state IDLE, overriding any simultaneous request.
REQ-026 SHALL, if reset is asserted mid-tenure, drop the grant on the next edge, ignore bus_rdy_, and have the first post-reset grant follow REQ-011 with ptr=0.

Structure
REQ-027 SHALL take the master count (4), the owner-index width (2) and the MAX_TENURE default from the shared bus.h header; none are local literals.
REQ-028 SHALL put the rotating search in one combinational sub-module, bus_rr_pick, with inputs 4-bit request vector and 2-bit start index, and outputs found and 2-bit index; it is instantiated once.
REQ-029 SHALL keep the state, owner, ptr and tenure registers in bus_arbiter itself.

Verification
REQ-030 SHALL cover: reset, then m2_req_=0 at cycle 3 -> m2_grnt_=0 at cycle 4, bus_owner=2, bus_busy=1.
REQ-031 SHALL cover: all four requests low from IDLE with ptr=0 -> grant order m0, m1, m2, m3, each owner releasing after 2 cycles, no idle gap between owners.
REQ-032 SHALL cover: m1 owns with m3 requesting, and m1 releases with bus_rdy_=1 -> m3_grnt_=0 next cycle and m1_grnt_=1 in that same cycle.
REQ-033 SHALL cover: m0 holds 16 cycles with m1 requesting and bus_rdy_=1 for cycles 16-19 -> m0 keeps the grant; bus_rdy_=0 at cycle 20 -> m1 granted at cycle 21.
REQ-034 SHALL cover: m0 sole requester for 40 cycles with bus_rdy_ toggling -> m0 granted throughout, tenure stuck at 16.
REQ-035 SHALL cover: reset=1 while m2 owns -> all grants high next edge; on release of reset with m2 and m3 requesting -> m2 granted (ptr=0 search).

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared sizing constants and state type for the bus arbiter
package bus_arbiter_pkg;
  localparam int N_MASTERS = 4;
  localparam int OWNER_W = 2;
  localparam int DEF_MAX_TENURE = 16;
  typedef enum logic {IDLE, OWNED} state_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: active-low request/grant bus between four masters and the arbiter
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;
  logic m0_req_, m1_req_, m2_req_, m3_req_;
  logic m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic bus_rdy_;
  logic [OWNER_W-1:0] bus_owner;
  logic bus_busy;
  modport slave (
    input m0_req_, m1_req_, m2_req_, m3_req_, bus_rdy_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_owner, bus_busy
  );
  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_, bus_rdy_,
    input m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, bus_owner, bus_busy
  );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// bus_rr_pick: first set request found searching start, start+1, ... modulo the master count
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  logic [OWNER_W-1:0]   start,
  output logic                 found,
  output logic [OWNER_W-1:0]   idx
);
  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    found = 1'b0;
    idx = start;
    for (int i = N_MASTERS - 1; i >= 0; i--)
      if (req[start + OWNER_W'(i)]) begin
        found = 1'b1;
        idx = start + OWNER_W'(i);
      end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for four active-low masters with a tenure limit
//   that only forces a handover at a transfer boundary (bus_rdy_ low).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_TENURE = DEF_MAX_TENURE,
  parameter int TENURE_W = 5
) (
  input logic clk,
  input logic reset,
  bus_arbiter_if.slave bus
);
  state_t state;
  logic [OWNER_W-1:0] owner, ptr, start, pick;
  logic [TENURE_W-1:0] tenure;
  logic [N_MASTERS-1:0] req, cand, grnt;
  logic found, busy, at_max, rel, yield;
  assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  // While owned, the search skips the owner so a forced yield never re-picks it.
  assign cand = state == OWNED ? req & ~(N_MASTERS'(1) << owner) : req;
  assign start = state == OWNED ? owner + 1'b1 : ptr;
  assign rel = !req[owner];
  assign at_max = tenure == TENURE_W'(MAX_TENURE);
  assign yield = rel || (at_max && found && !bus.bus_rdy_);
  bus_rr_pick u_pick (
    .req(cand),
    .start(start),
    .found(found),
    .idx(pick)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      tenure <= '0;
      grnt <= '1;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= OWNED;
        owner <= pick;
        tenure <= '0;
        grnt <= ~(N_MASTERS'(1) << pick);
        busy <= 1'b1;
      end
    end else if (yield && found) begin
      owner <= pick;
      tenure <= '0;
      grnt <= ~(N_MASTERS'(1) << pick);
    end else if (yield) begin
      state <= IDLE;
      ptr <= owner + 1'b1;
      grnt <= '1;
      busy <= 1'b0;
    end else if (!at_max) begin
      tenure <= tenure + 1'b1;
    end
  end
  assign bus.m0_grnt_ = grnt[0];
  assign bus.m1_grnt_ = grnt[1];
  assign bus.m2_grnt_ = grnt[2];
  assign bus.m3_grnt_ = grnt[3];
  assign bus.bus_owner = owner;
  assign bus.bus_busy = busy;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scenario tasks pushing expected grant/owner/busy per cycle to a scoreboard
module tb_bus_arbiter;
  typedef struct packed {
    logic [3:0] g;
    logic [1:0] o;
    logic b;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t e;
  bus_arbiter_if bus ();
  bus_arbiter #(.MAX_TENURE(16), .TENURE_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] gv();
    return {bus.m3_grnt_, bus.m2_grnt_, bus.m1_grnt_, bus.m0_grnt_};
  endfunction
  task automatic drive(input logic rs, input logic [3:0] r, input logic rd);
    reset = rs;
    {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_} = r;
    bus.bus_rdy_ = rd;
  endtask
  task automatic do_reset();
    drive(1'b1, 4'hF, 1'b1);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [3:0] rq[3] = '{4'h0, 4'h0, 4'hF};
    logic rs[3] = '{1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      drive(rs[c], rq[c], 1'b0);
      sb.push_back('{g: 4'hF, o: 2'd0, b: 1'b0});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (gv() !== e.g || bus.bus_busy !== e.b || bus.bus_owner !== e.o) begin
        errors++;
        $display("FAIL reset c%0d: grnt=%b busy=%b owner=%0d, expected grnt=%b busy=%b owner=%0d", c, gv(), bus.bus_busy, bus.bus_owner, e.g, e.b, e.o);
      end
    end
  endtask
  task automatic test_single();
    logic [3:0] rq[5] = '{4'hF, 4'hF, 4'b1011, 4'b1011, 4'hF};
    logic [3:0] eg[5] = '{4'hF, 4'hF, 4'b1011, 4'b1011, 4'hF};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, rq[c], 1'b1);
      sb.push_back('{g: eg[c], o: 2'd2, b: eg[c] != 4'hF});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (gv() !== e.g || bus.bus_busy !== e.b || (e.b && bus.bus_owner !== e.o)) begin
        errors++;
        $display("FAIL single c%0d: grnt=%b busy=%b owner=%0d, expected grnt=%b busy=%b owner=%0d", c, gv(), bus.bus_busy, bus.bus_owner, e.g, e.b, e.o);
      end
    end
  endtask
  task automatic test_round_robin();
    logic [3:0] rq[9] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF};
    logic [3:0] eg[9] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hF};
    int eo[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(1'b0, rq[c], 1'b1);
      sb.push_back('{g: eg[c], o: 2'(eo[c]), b: eg[c] != 4'hF});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (gv() !== e.g || bus.bus_busy !== e.b || (e.b && bus.bus_owner !== e.o)) begin
        errors++;
        $display("FAIL round_robin c%0d: grnt=%b busy=%b owner=%0d, expected grnt=%b busy=%b owner=%0d", c, gv(), bus.bus_busy, bus.bus_owner, e.g, e.b, e.o);
      end
    end
  endtask
  task automatic test_release();
    logic [3:0] rq[8] = '{4'hD, 4'h5, 4'h7, 4'hF, 4'hD, 4'h5, 4'hD, 4'hF};
    logic [3:0] eg[8] = '{4'hD, 4'hD, 4'h7, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF};
    int eo[8] = '{1, 1, 3, 0, 1, 1, 1, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, rq[c], 1'b1);
      sb.push_back('{g: eg[c], o: 2'(eo[c]), b: eg[c] != 4'hF});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (gv() !== e.g || bus.bus_busy !== e.b || (e.b && bus.bus_owner !== e.o)) begin
        errors++;
        $display("FAIL release c%0d: grnt=%b busy=%b owner=%0d, expected grnt=%b busy=%b owner=%0d", c, gv(), bus.bus_busy, bus.bus_owner, e.g, e.b, e.o);
      end
    end
  endtask
  task automatic test_tenure();
    logic [3:0] r;
    logic rd;
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      r = c == 24 ? 4'hF : 4'hC;
      rd = !(c == 5 || c == 17 || c == 22);
      drive(1'b0, r, rd);
      sb.push_back(c == 24 ? '{g: 4'hF, o: 2'd0, b: 1'b0} :
                   c >= 22 ? '{g: 4'hD, o: 2'd1, b: 1'b1} : '{g: 4'hE, o: 2'd0, b: 1'b1});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (gv() !== e.g || bus.bus_busy !== e.b || (e.b && bus.bus_owner !== e.o)) begin
        errors++;
        $display("FAIL tenure edge%0d: grnt=%b busy=%b owner=%0d, expected grnt=%b busy=%b owner=%0d", c, gv(), bus.bus_busy, bus.bus_owner, e.g, e.b, e.o);
      end
    end
  endtask
  task automatic test_sole();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      drive(1'b0, 4'hE, c[0]);
      sb.push_back('{g: 4'hE, o: 2'd0, b: 1'b1});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (gv() !== e.g || bus.bus_busy !== e.b || bus.bus_owner !== e.o) begin
        errors++;
        $display("FAIL sole c%0d: grnt=%b busy=%b owner=%0d, expected grnt=%b busy=%b owner=%0d", c, gv(), bus.bus_busy, bus.bus_owner, e.g, e.b, e.o);
      end
    end
    checks++;
    if (dut.tenure !== 5'd16) begin
      errors++;
      $display("FAIL sole_tenure: tenure=%0d, expected 16", dut.tenure);
    end
    drive(1'b0, 4'hF, 1'b1);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_mid();
    logic rs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] rq[8] = '{4'hB, 4'hF, 4'hB, 4'h3, 4'h3, 4'h3, 4'h7, 4'hF};
    logic rd[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] eg[8] = '{4'hB, 4'hF, 4'hB, 4'hB, 4'hF, 4'hB, 4'h7, 4'hF};
    int eo[8] = '{2, 0, 2, 2, 0, 2, 3, 0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(rs[c], rq[c], rd[c]);
      sb.push_back('{g: eg[c], o: 2'(eo[c]), b: eg[c] != 4'hF});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (gv() !== e.g || bus.bus_busy !== e.b || (e.b && bus.bus_owner !== e.o)) begin
        errors++;
        $display("FAIL reset_mid c%0d: grnt=%b busy=%b owner=%0d, expected grnt=%b busy=%b owner=%0d", c, gv(), bus.bus_busy, bus.bus_owner, e.g, e.b, e.o);
      end
    end
  endtask
  initial begin
    drive(1'b1, 4'hF, 1'b1);
    test_reset();
    test_single();
    test_round_robin();
    test_release();
    test_tenure();
    test_sole();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
